mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, busy cycles for MULT/MULTU (range 1-15).
REQ-002 SHALL have parameter DIV_CYC, default 10, busy cycles for DIV/DIVU (range 1-15).
REQ-003 SHALL have port clk  in  1  sole clock; all state rising-edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  E-stage MD instruction valid this cycle.
REQ-006 SHALL have port op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port rs  in  32  forwarded E-stage rs operand.
REQ-008 SHALL have port rt  in  32  forwarded E-stage rt operand.
REQ-009 SHALL have port md_use_D  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-010 SHALL have port busy  out  1  unit is computing.
REQ-011 SHALL have port stall_D  out  1  stall request to hazard control (freeze PC and FD, flush DE).
REQ-012 SHALL have port hi  out  32  HI register.
REQ-013 SHALL have port lo  out  32  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV and a 4-bit down-counter.
REQ-015 SHALL, in IDLE with start=1 and op 0-1, latch rs/rt/op, load counter with MULT_CYC-1, and enter MUL at the next edge.
REQ-016 SHALL, in IDLE with start=1 and op 2-3, latch rs/rt/op, load counter with DIV_CYC-1, and enter DIV at the next edge.
REQ-017 SHALL decrement the counter each cycle in MUL/DIV; at counter=0 it SHALL write the result to hi/lo and return to IDLE on that edge.
REQ-018 SHALL hold busy=1 exactly MULT_CYC (or DIV_CYC) cycles, beginning the cycle after start is sampled; results are visible in the first cycle busy=0.
REQ-019 SHALL compute MULT as signed 32x32->64 and MULTU as unsigned; hi=product[63:32], lo=product[31:0].
REQ-020 SHALL compute DIV as signed, truncating toward zero, with the remainder carrying the dividend's sign; DIVU unsigned; lo=quotient, hi=remainder.
REQ-021 SHALL, in IDLE with start=1 and op 4 (or 5), write rs to hi (or lo) at the next edge, with no busy cycles.
REQ-022 SHALL ignore start while in MUL/DIV; state, counter, latched operands and hi/lo SHALL be unaffected.
REQ-023 SHALL ignore start with op 6-7.
REQ-024 SHALL drive stall_D = md_use_D & (busy | (start & op<=3)) combinationally.
REQ-025 SHALL compute results only from latched operands; rs/rt changes during busy SHALL have no effect.
REQ-026 SHALL use the latched values for the final-edge write, so a divisor of 0 is evaluated per the Configuration section.

Reset
REQ-027 SHALL, on reset=0, immediately force state=IDLE, counter=0, busy=0, hi=0, lo=0, and latched operands=0, independent of clk.
REQ-028 SHALL, on assertion of reset mid-operation, abandon the operation with no hi/lo write.
REQ-029 SHALL resume normal operation at the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with MDU_DIVZERO_KEEP_EN defined, leave hi/lo unchanged when DIV/DIVU completes with a divisor of 0; busy timing is unchanged.
REQ-031 SHALL, with MDU_DIVZERO_KEEP_EN undefined, write hi=dividend and lo=32'hFFFFFFFF when DIV/DIVU completes with a divisor of 0.

Verification
REQ-032 SHALL check: MULT rs=32'hFFFFFFFD, rt=7 -> busy high for 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-033 SHALL check: MULTU rs=32'hFFFFFFFF, rt=2 -> hi=32'h00000001, lo=32'hFFFFFFFE after 5 busy cycles.
REQ-034 SHALL check: DIV rs=32'hFFFFFFF9 (-7), rt=2 -> 10 busy cycles, then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; md_use_D=1 throughout gives stall_D=1 for the start cycle plus 10 cycles.
REQ-035 SHALL check: DIVU rs=7, rt=0 with hi=lo=32'h5 beforehand -> macro defined: hi=lo=5; macro undefined: hi=7, lo=32'hFFFFFFFF.
REQ-036 SHALL check: a second start MULT issued during a DIV -> ignored, and only the DIV result is written.
REQ-037 SHALL check: reset=0 asserted at busy cycle 3 of a MULT -> busy=0 and hi=lo=0 immediately; after release, MTHI rs=32'h1234 -> hi=32'h1234 next cycle with busy=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers and D-stage stall.
// Optional macro MDU_DIVZERO_KEEP_EN: when defined, a divide by zero leaves HI/LO unchanged.
module mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] a_reg, a_next;
    logic [31:0] b_reg, b_next;
    logic        uns_reg, uns_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    // Datapath works only on latched operands, so E-stage forwarding changes cannot disturb it.
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] b_safe;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign a_ext  = uns_reg ? {32'b0, a_reg} : {{32{a_reg[31]}}, a_reg};
    assign b_ext  = uns_reg ? {32'b0, b_reg} : {{32{b_reg[31]}}, b_reg};
    assign prod   = a_ext * b_ext;
    // Substitute divisor keeps the divider free of X when the zero case is overridden below.
    assign b_safe = (b_reg == 32'd0) ? 32'd1 : b_reg;
    assign quo_s  = $unsigned($signed(a_reg) / $signed(b_safe));
    assign rem_s  = $unsigned($signed(a_reg) % $signed(b_safe));
    assign quo_u  = a_reg / b_safe;
    assign rem_u  = a_reg % b_safe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            uns_reg   <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            uns_reg   <= uns_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        uns_next   = uns_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0, 3'd1: begin
                            a_next     = rs;
                            b_next     = rt;
                            uns_next   = op[0];
                            cnt_next   = MULT_LOAD;
                            state_next = MUL;
                        end
                        3'd2, 3'd3: begin
                            a_next     = rs;
                            b_next     = rt;
                            uns_next   = op[0];
                            cnt_next   = DIV_LOAD;
                            state_next = DIV;
                        end
                        3'd4:    hi_next = rs;
                        3'd5:    lo_next = rs;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt_reg == 4'd0) begin
                    hi_next    = prod[63:32];
                    lo_next    = prod[31:0];
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            DIV: begin
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                    if (b_reg == 32'd0) begin
`ifdef MDU_DIVZERO_KEEP_EN
                        hi_next = hi_reg;
                        lo_next = lo_reg;
`else
                        hi_next = a_reg;
                        lo_next = 32'hFFFF_FFFF;
`endif
                    end else begin
                        hi_next = uns_reg ? rem_u : rem_s;
                        lo_next = uns_reg ? quo_u : quo_s;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign stall_D = md_use_D & (busy | (start & (op <= 3'd3)));
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default parameters; honours MDU_DIVZERO_KEEP_EN).
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        md_use_D;
    logic        busy;
    logic        stall_D;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs       (rs),
        .rt       (rt),
        .md_use_D (md_use_D),
        .busy     (busy),
        .stall_D  (stall_D),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a start for one cycle; returns in the first cycle after it was sampled.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall_D !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h required 0/0/0/0", busy, stall_D, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_mult();
        int n;
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        count_busy(n);
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL mult_busy: got %0d cycles required 5", n);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_result: hi=%h lo=%h required ffffffff/ffffffeb", hi, lo);
        end
        $display("MULT -3*7: busy=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_multu();
        int n;
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        checks++;
        if (n !== 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu: busy=%0d hi=%h lo=%h required 5/00000001/fffffffe", n, hi, lo);
        end
        $display("MULTU ffffffff*2: busy=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_div_stall();
        int n;
        int stalls;
        md_use_D = 1'b1;
        stalls   = 0;
        @(negedge clk);
        start = 1'b1;
        op    = 3'd2;
        rs    = 32'hFFFF_FFF9;
        rt    = 32'd2;
        #1;
        if (stall_D === 1'b1) stalls++;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            if (stall_D === 1'b1) stalls++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL div_busy: got %0d cycles required 10", n);
        end
        checks++;
        if (stalls !== 11 || stall_D !== 1'b0) begin
            errors++;
            $display("FAIL div_stall: stall cycles=%0d final=%b required 11/0", stalls, stall_D);
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_result: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
        end
        md_use_D = 1'b0;
        $display("DIV -7/2: busy=%0d stalls=%0d hi=%h lo=%h", n, stalls, hi, lo);
    endtask

    task automatic test_div_sign();
        int n;
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        count_busy(n);
        checks++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_sign: hi=%h lo=%h required 00000001/fffffffd", hi, lo);
        end
        $display("DIV 7/-2: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'd5;
        @(negedge clk);
        op    = 3'd5;
        rs    = 32'd5;
        checks++;
        if (hi !== 32'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b required 00000005/0", hi, busy);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        checks++;
        if (lo !== 32'd5 || hi !== 32'd5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b required 5/5/0", hi, lo, busy);
        end
        $display("MTHI/MTLO back-to-back: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_divzero();
        int n;
        issue(3'd3, 32'd7, 32'd0);
        count_busy(n);
        checks++;
`ifdef MDU_DIVZERO_KEEP_EN
        if (n !== 10 || hi !== 32'd5 || lo !== 32'd5) begin
            errors++;
            $display("FAIL divzero: busy=%0d hi=%h lo=%h required 10/5/5", n, hi, lo);
        end
`else
        if (n !== 10 || hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL divzero: busy=%0d hi=%h lo=%h required 10/00000007/ffffffff", n, hi, lo);
        end
`endif
        $display("DIVU 7/0: busy=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_ignore_start();
        int n;
        issue(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        rs    = 32'd3;
        rt    = 32'd4;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        rs    = 32'hDEAD_BEEF;
        rt    = 32'd1;
        n = 2;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL ignore_busy: got %0d cycles required 10", n);
        end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL ignore_result: hi=%h lo=%h required 00000002/0000000e", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL ignore_after: busy=%b hi=%h lo=%h required 0/2/e", busy, hi, lo);
        end
        $display("DIVU 100/7 with MULT during busy: busy=%0d hi=%h lo=%h", n, hi, lo);
    endtask

    task automatic test_noop();
        @(negedge clk);
        start = 1'b1;
        op    = 3'd6;
        rs    = 32'h7777;
        rt    = 32'h1;
        md_use_D = 1'b1;
        #1;
        checks++;
        if (stall_D !== 1'b0) begin
            errors++;
            $display("FAIL noop_stall: stall=%b required 0", stall_D);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'd7;
        md_use_D = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL noop: busy=%b hi=%h lo=%h required 0/2/e", busy, hi, lo);
        end
        $display("op 6: busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_reset_mid();
        issue(3'd0, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b required 1", busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd4, 32'h1234, 32'd0);
        checks++;
        if (hi !== 32'h1234 || lo !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_mthi: hi=%h lo=%h busy=%b required 00001234/0/0", hi, lo, busy);
        end
        $display("reset mid-MULT then MTHI: hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    initial begin
        start    = 1'b0;
        op       = 3'd7;
        rs       = 32'd0;
        rt       = 32'd0;
        md_use_D = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div_stall();
        test_div_sign();
        test_back_to_back();
        test_divzero();
        test_ignore_start();
        test_noop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
